spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- SPI initiator: serialises one DATA_WIDTH-bit word MSB-first on spi_out and deserialises spi_in into bus_out over one framed transfer.
- Generates spi_clk with programmable polarity, phase and rate, and drives the active-low frame select spi_ss.
- Sits opposite the existing spi_slave on the same 4-wire bus and uses the same polarity/phase convention.
- The host side is a start/busy/done handshake on the system clock.

Parameters:
DATA_WIDTH, 8, bits per transfer; bus_in/bus_out width.
DIV_WIDTH, 8, width of clk_div.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
ena  in  1  clock enable; low = every register holds
spi_clk_polarity  in  1  idle level of spi_clk (CPOL)
spi_clk_phase  in  1  0: sample on leading edge; 1: sample on trailing edge (CPHA)
clk_div  in  DIV_WIDTH  half-period H = clk_div+1 clk cycles
start  in  1  request transfer; accepted only in IDLE with ena=1
bus_in  in  DATA_WIDTH  transmit word, captured at start acceptance
bus_out  out  DATA_WIDTH  received word, updated with done
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at end of transfer
spi_out  out  1  MOSI
spi_in  in  1  MISO
spi_clk  out  1  serial clock
spi_ss  out  1  frame select, active-low

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clock edge) gives: state=IDLE, spi_ss=1, spi_clk=0, spi_out=0, busy=0, done=0, bus_out=0, divider and bit counters=0.
- Reset is honoured regardless of ena.
- Reset mid-transfer aborts: spi_ss=1 the next cycle, bus_out is not updated, and no done pulse is generated.
- ena=0 freezes all state, including the divider. The start input is ignored while ena=0.
- IDLE:
  - spi_ss=1, busy=0, spi_out=0.
  - spi_clk follows spi_clk_polarity with one cycle of delay.
  - If start=1 in cycle 0: capture bus_in, spi_clk_polarity, spi_clk_phase and clk_div; go to SETUP.
  - Config input changes after capture are ignored until the next start.
- Cycle numbering below is relative to start acceptance in cycle 0.
- SETUP (cycles 1..H):
  - spi_ss=0, busy=1.
  - CPHA=0: spi_out=MSB from cycle 1.
  - CPHA=1: spi_out keeps its previous value.
- SHIFT:
  - spi_clk toggles 2*DATA_WIDTH times; edge k (k=1..2*DATA_WIDTH) becomes visible at cycle k*H+1.
  - Odd k is the leading edge (away from CPOL); even k is the trailing edge.
  - CPHA=0:
    - Sample spi_in on odd k.
    - Drive the next bit on even k, except the last edge.
  - CPHA=1:
    - Drive a bit on odd k; the first odd edge drives the MSB.
    - Sample spi_in on even k.
  - Sampling captures spi_in at the clk edge that updates spi_clk to the sample edge. The slave must therefore hold MISO stable through that cycle.
  - Bits are received MSB-first.
- HOLD (cycles 2*DATA_WIDTH*H+1 .. (2*DATA_WIDTH+1)*H):
  - spi_clk=CPOL, spi_ss=0, spi_out holds.
- End of transfer, at cycle (2*DATA_WIDTH+1)*H+1:
  - spi_ss=1, busy=0, done=1 for one cycle, bus_out = received word, state=IDLE.
  - With DATA_WIDTH=8: done at cycle 17H+1.
- Back-to-back: start in the done cycle is accepted. spi_ss is then high for exactly 1 cycle and SETUP begins next.
- start while busy=1 is ignored, with no side effect.
- The divider counts 0..clk_div and wraps. clk_div=0 gives H=1, so spi_clk is clk/2.
- The maximum divider value gives H=2^DIV_WIDTH with no overflow.
- spi_out changes only on drive edges or in SETUP. It is never glitched on a sample edge.

Test Plan:
- Mode 0 loopback, spi_out tied to spi_in, clk_div=0, bus_in=0xA5, start pulse at cycle 0:
  - spi_ss low cycles 1..17.
  - 16 spi_clk edges at cycles 2..17.
  - done at cycle 18, bus_out=0xA5, busy low at 18.
- Mode 3 (CPOL=1, CPHA=1) against the spi_slave model returning 0x3C, bus_in=0xC3, clk_div=3 (H=4):
  - Slave receives 0xC3.
  - bus_out=0x3C.
  - spi_clk idle-high before and after the frame.
  - done at cycle 69.
- Modes 1 and 2 sweep with bus_in=0x81 looped back:
  - spi_out transitions only on drive edges (CPHA-dependent).
  - bus_out=0x81 in both modes.
- start held high continuously for 2 transfers, clk_div=1:
  - Second transfer starts in the done cycle.
  - spi_ss high for exactly 1 cycle between frames.
  - Extra start pulses while busy produce no extra frames.
- Reset asserted at cycle 10 of a clk_div=0 transfer:
  - Next cycle: spi_ss=1, busy=0, spi_out=0, spi_clk=0.
  - No done pulse; bus_out stays 0x00.
  - A new start afterwards completes normally.
- ena=0 for 5 cycles mid-SHIFT:
  - spi_clk, spi_out and counters frozen.
  - done delayed by exactly 5 cycles; data correct.

Source files
------------

// File: rtl/spi_master.sv
// SPI initiator: one DATA_WIDTH-bit MSB-first transfer per start, programmable CPOL/CPHA/rate.
// Host side is a start/busy/done handshake; every output is driven straight from a register.
module spi_master #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIV_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ena_i,
    input  logic                  spi_clk_polarity_i,
    input  logic                  spi_clk_phase_i,
    input  logic [DIV_WIDTH-1:0]  clk_div_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] bus_in_i,
    output logic [DATA_WIDTH-1:0] bus_out_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  spi_out_o,
    input  logic                  spi_in_i,
    output logic                  spi_clk_o,
    output logic                  spi_ss_o
);

    localparam int unsigned NumEdges = 2 * DATA_WIDTH;
    localparam int unsigned CntW     = $clog2(NumEdges + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    state_e                state_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  hdiv_q;
    logic [CntW-1:0]       edge_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [DATA_WIDTH-1:0] bus_out_q;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  spi_out_q;
    logic                  spi_clk_q;
    logic                  spi_ss_q;

    logic tick;
    logic last_edge;
    logic sample_now;
    logic drive_now;

    // edge_q counts edges already produced, so the next edge is odd (leading) when edge_q is even.
    always_comb begin
        tick       = (div_q == hdiv_q);
        last_edge  = (edge_q == CntW'(NumEdges - 1));
        sample_now = ~edge_q[0] ^ cpha_q;
        drive_now  = ~sample_now & ~last_edge;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            div_q     <= '0;
            hdiv_q    <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            bus_out_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            spi_out_q <= 1'b0;
            spi_clk_q <= 1'b0;
            spi_ss_q  <= 1'b1;
        end else if (ena_i) begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    spi_ss_q  <= 1'b1;
                    busy_q    <= 1'b0;
                    spi_out_q <= 1'b0;
                    spi_clk_q <= spi_clk_polarity_i;
                    div_q     <= '0;
                    edge_q    <= '0;
                    if (start_i) begin
                        state_q  <= StSetup;
                        cpol_q   <= spi_clk_polarity_i;
                        cpha_q   <= spi_clk_phase_i;
                        hdiv_q   <= clk_div_i;
                        rx_q     <= '0;
                        spi_ss_q <= 1'b0;
                        busy_q   <= 1'b1;
                        // CPHA=0 presents the MSB before the first (sampling) edge.
                        if (!spi_clk_phase_i) begin
                            spi_out_q <= bus_in_i[DATA_WIDTH-1];
                            tx_q      <= {bus_in_i[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            tx_q <= bus_in_i;
                        end
                    end
                end
                StSetup, StShift: begin
                    if (tick) begin
                        div_q     <= '0;
                        spi_clk_q <= ~spi_clk_q;
                        edge_q    <= edge_q + CntW'(1);
                        if (sample_now) begin
                            rx_q <= {rx_q[DATA_WIDTH-2:0], spi_in_i};
                        end
                        if (drive_now) begin
                            spi_out_q <= tx_q[DATA_WIDTH-1];
                            tx_q      <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                        end
                        state_q <= last_edge ? StHold : StShift;
                    end else begin
                        div_q <= div_q + DIV_WIDTH'(1);
                    end
                end
                StHold: begin
                    if (tick) begin
                        div_q     <= '0;
                        state_q   <= StIdle;
                        spi_ss_q  <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        bus_out_q <= rx_q;
                        spi_out_q <= 1'b0;
                        spi_clk_q <= cpol_q;
                    end else begin
                        div_q <= div_q + DIV_WIDTH'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_out_o = bus_out_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign spi_out_o = spi_out_q;
    assign spi_clk_o = spi_clk_q;
    assign spi_ss_o  = spi_ss_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: loopback and a behavioural SPI slave, timing predicted from H=clk_div+1.
`timescale 1ns/1ps
module tb_spi_master;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic         cpol_in = 1'b0;
    logic         cpha_in = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   clk_div = 8'd0;
    logic [W-1:0] bus_in = '0;
    logic [W-1:0] bus_out;
    logic         busy, done, spi_out, spi_clk, spi_ss, spi_in;

    int checks = 0;
    int errors = 0;

    // Slave mode and data, set by the tests
    logic       s_cpol = 1'b0;
    logic       s_cpha = 1'b0;
    logic       loop_en = 1'b0;
    logic [7:0] s_tx_word = 8'd0;

    logic [7:0] slv_sh = 8'd0;
    logic [7:0] slv_rcv = 8'd0;
    logic       slv_miso = 1'b0;
    logic       slv_prev_clk = 1'b0;
    logic       slv_prev_ss = 1'b1;

    int   mon_edges = 0, mon_glitch = 0, mon_done = 0, mon_frames = 0;
    int   mon_hi_run = 0, mon_last_gap = 0;
    logic mon_prev_clk = 1'b0, mon_prev_ss = 1'b1, mon_prev_out = 1'b0;

    assign spi_in = loop_en ? spi_out : slv_miso;

    always #5 clk = ~clk;

    spi_master #(.DATA_WIDTH(W), .DIV_WIDTH(8)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .ena_i              (ena),
        .spi_clk_polarity_i (cpol_in),
        .spi_clk_phase_i    (cpha_in),
        .clk_div_i          (clk_div),
        .start_i            (start),
        .bus_in_i           (bus_in),
        .bus_out_o          (bus_out),
        .busy_o             (busy),
        .done_o             (done),
        .spi_out_o          (spi_out),
        .spi_in_i           (spi_in),
        .spi_clk_o          (spi_clk),
        .spi_ss_o           (spi_ss)
    );

    // Behavioural slave: samples MOSI on its sample edge, shifts MISO on the other edge.
    always @(negedge clk) begin
        if (!spi_ss) begin
            if (slv_prev_ss) begin
                slv_rcv <= 8'd0;
                if (!s_cpha) begin
                    slv_miso <= s_tx_word[7];
                    slv_sh   <= {s_tx_word[6:0], 1'b0};
                end else begin
                    slv_sh <= s_tx_word;
                end
            end else if (spi_clk !== slv_prev_clk) begin
                if ((spi_clk != s_cpol) != s_cpha) begin
                    slv_rcv <= {slv_rcv[6:0], spi_out};
                end else begin
                    slv_miso <= slv_sh[7];
                    slv_sh   <= {slv_sh[6:0], 1'b0};
                end
            end
        end
        slv_prev_clk <= spi_clk;
        slv_prev_ss  <= spi_ss;
    end

    // Bus monitor: clock edges inside frames, MOSI changes off drive edges, frames, gaps, dones.
    always @(negedge clk) begin
        if (!spi_ss && !mon_prev_ss) begin
            if (spi_clk !== mon_prev_clk) mon_edges <= mon_edges + 1;
            if (spi_out !== mon_prev_out &&
                !(spi_clk !== mon_prev_clk && ((spi_clk == s_cpol) != s_cpha)))
                mon_glitch <= mon_glitch + 1;
        end
        if (done === 1'b1) mon_done <= mon_done + 1;
        if (!spi_ss && mon_prev_ss) begin
            mon_frames   <= mon_frames + 1;
            mon_last_gap <= mon_hi_run;
        end
        mon_hi_run   <= spi_ss ? mon_hi_run + 1 : 0;
        mon_prev_clk <= spi_clk;
        mon_prev_ss  <= spi_ss;
        mon_prev_out <= spi_out;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Cycle (relative to start acceptance in cycle 0) at which done is visible.
    function automatic int exp_done(input int div);
        return (2 * W + 1) * (div + 1) + 1;
    endfunction

    task automatic do_xfer(input logic [7:0] word, input logic [7:0] sword, input logic pol,
                           input logic pha, input logic [7:0] div, input logic lp,
                           input bit scramble, output int done_t, output logic clk_before);
        int t;
        int lim;
        s_cpol = pol; s_cpha = pha; s_tx_word = sword; loop_en = lp;
        cpol_in = pol; cpha_in = pha; clk_div = div; bus_in = word;
        tick(); tick();
        clk_before = spi_clk;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 1;
        if (scramble) begin
            bus_in  = 8'($urandom);
            cpol_in = 1'($urandom);
            cpha_in = 1'($urandom);
            clk_div = 8'($urandom_range(0, 255));
        end
        lim = exp_done(int'(div)) + 20;
        while (done !== 1'b1 && t < lim) begin
            tick();
            t++;
        end
        done_t = (done === 1'b1) ? t : -1;
        cpol_in = pol; cpha_in = pha; clk_div = div; bus_in = word;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpol_in = 1'b1;
        tick(); tick();
        checks++; if (spi_ss !== 1'b1) begin errors++; $display("FAIL reset_ss: got %b want 1", spi_ss); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b want 0", spi_clk); end
        checks++; if (spi_out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b want 0", spi_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL reset_bus_out: got %h want 00", bus_out); end
        rst_n = 1'b1;
        tick();
        checks++; if (spi_clk !== 1'b1) begin errors++; $display("FAIL idle_clk_follow1: got %b want 1", spi_clk); end
        cpol_in = 1'b0;
        tick();
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL idle_clk_follow0: got %b want 0", spi_clk); end
    endtask

    task automatic test_mode0_loopback();
        int bad_ss = 0, bad_clk = 0, bad_done = 0, bad_busy = 0;
        logic prev;
        s_cpol = 1'b0; s_cpha = 1'b0; loop_en = 1'b1;
        cpol_in = 1'b0; cpha_in = 1'b0; clk_div = 8'd0; bus_in = 8'hA5;
        tick(); tick();
        prev = spi_clk;
        start = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            start = 1'b0;
            if (spi_ss !== ((t >= 1 && t <= 17) ? 1'b0 : 1'b1)) bad_ss++;
            if ((spi_clk !== prev) != (t >= 2 && t <= 17)) bad_clk++;
            if (done !== ((t == 18) ? 1'b1 : 1'b0)) bad_done++;
            if (t <= 17 && busy !== 1'b1) bad_busy++;
            prev = spi_clk;
            if (t == 18) begin
                checks++; if (bus_out !== 8'hA5) begin errors++; $display("FAIL mode0_bus_out: got %h want a5", bus_out); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mode0_busy_end: got %b want 0", busy); end
            end
        end
        checks++; if (bad_ss != 0) begin errors++; $display("FAIL mode0_ss_window: %0d bad cycles, want 0", bad_ss); end
        checks++; if (bad_clk != 0) begin errors++; $display("FAIL mode0_clk_edges: %0d bad cycles, want 0", bad_clk); end
        checks++; if (bad_done != 0) begin errors++; $display("FAIL mode0_done_cycle: %0d bad cycles, want 0", bad_done); end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL mode0_busy: %0d bad cycles, want 0", bad_busy); end
    endtask

    task automatic test_mode3_slave();
        int dt;
        logic cb;
        do_xfer(8'hC3, 8'h3C, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, dt, cb);
        checks++; if (cb !== 1'b1) begin errors++; $display("FAIL mode3_idle_before: got %b want 1", cb); end
        checks++; if (dt != 69) begin errors++; $display("FAIL mode3_done_cycle: got %0d want 69", dt); end
        checks++; if (bus_out !== 8'h3C) begin errors++; $display("FAIL mode3_bus_out: got %h want 3c", bus_out); end
        checks++; if (slv_rcv !== 8'hC3) begin errors++; $display("FAIL mode3_slave_rx: got %h want c3", slv_rcv); end
        tick(); tick();
        checks++; if (spi_clk !== 1'b1) begin errors++; $display("FAIL mode3_idle_after: got %b want 1", spi_clk); end
    endtask

    task automatic test_modes_1_2();
        int dt, e0, g0;
        logic [7:0] div;
        logic cb;
        for (int m = 0; m < 2; m++) begin
            div = 8'($urandom_range(0, 2));
            e0 = mon_edges; g0 = mon_glitch;
            do_xfer(8'h81, 8'h00, 1'(m), 1'(1 - m), div, 1'b1, 1'b0, dt, cb);
            checks++; if (dt != exp_done(int'(div))) begin errors++; $display("FAIL mode%0d_done: got %0d want %0d", m + 1, dt, exp_done(int'(div))); end
            checks++; if (bus_out !== 8'h81) begin errors++; $display("FAIL mode%0d_bus_out: got %h want 81", m + 1, bus_out); end
            checks++; if (mon_glitch != g0) begin errors++; $display("FAIL mode%0d_mosi_edges: %0d off-edge changes, want 0", m + 1, mon_glitch - g0); end
            checks++; if (mon_edges - e0 != 2 * W) begin errors++; $display("FAIL mode%0d_clk_edges: got %0d want %0d", m + 1, mon_edges - e0, 2 * W); end
        end
    endtask

    task automatic test_back_to_back();
        int t, t1, f0, d0;
        logic [7:0] w1, w2, sw1, sw2, bo1;
        w1 = 8'($urandom); w2 = 8'($urandom); sw1 = 8'($urandom); sw2 = ~sw1;
        s_cpol = 1'b0; s_cpha = 1'b0; loop_en = 1'b0; s_tx_word = sw1;
        cpol_in = 1'b0; cpha_in = 1'b0; clk_div = 8'd1; bus_in = w1;
        tick(); tick();
        f0 = mon_frames; d0 = mon_done;
        start = 1'b1;
        t = 0;
        do begin tick(); t++; if (t == 1) begin bus_in = w2; s_tx_word = sw2; end end
        while (done !== 1'b1 && t < 100);
        t1 = t;
        bo1 = bus_out;
        do begin tick(); t++; end while (done !== 1'b1 && t < 200);
        start = 1'b0;
        checks++; if (t1 != exp_done(1)) begin errors++; $display("FAIL b2b_first_done: got %0d want %0d", t1, exp_done(1)); end
        checks++; if (t - t1 != exp_done(1)) begin errors++; $display("FAIL b2b_second_done: got %0d want %0d", t - t1, exp_done(1)); end
        checks++; if (bo1 !== sw1) begin errors++; $display("FAIL b2b_bus_out1: got %h want %h", bo1, sw1); end
        checks++; if (bus_out !== sw2) begin errors++; $display("FAIL b2b_bus_out2: got %h want %h", bus_out, sw2); end
        checks++; if (slv_rcv !== w2) begin errors++; $display("FAIL b2b_slave_rx2: got %h want %h", slv_rcv, w2); end
        checks++; if (mon_last_gap != 1) begin errors++; $display("FAIL b2b_ss_gap: got %0d want 1", mon_last_gap); end
        for (int i = 0; i < 40; i++) tick();
        checks++; if (mon_frames - f0 != 2) begin errors++; $display("FAIL b2b_frames: got %0d want 2", mon_frames - f0); end
        checks++; if (mon_done - d0 != 2) begin errors++; $display("FAIL b2b_dones: got %0d want 2", mon_done - d0); end
    endtask

    task automatic test_reset_mid();
        int dt, d0;
        logic cb;
        logic [7:0] w;
        s_cpol = 1'b1; s_cpha = 1'b0; loop_en = 1'b1;
        cpol_in = 1'b1; cpha_in = 1'b0; clk_div = 8'd0; bus_in = 8'hA5;
        tick(); tick();
        d0 = mon_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 2; t <= 10; t++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (spi_ss !== 1'b1) begin errors++; $display("FAIL rstmid_ss: got %b want 1", spi_ss); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (spi_out !== 1'b0) begin errors++; $display("FAIL rstmid_out: got %b want 0", spi_out); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL rstmid_clk: got %b want 0", spi_clk); end
        for (int i = 0; i < 30; i++) tick();
        checks++; if (mon_done != d0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", mon_done - d0); end
        checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL rstmid_bus_out: got %h want 00", bus_out); end
        w = 8'($urandom);
        do_xfer(w, 8'h00, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, dt, cb);
        checks++; if (dt != exp_done(0)) begin errors++; $display("FAIL rstmid_after_done: got %0d want %0d", dt, exp_done(0)); end
        checks++; if (bus_out !== w) begin errors++; $display("FAIL rstmid_after_data: got %h want %h", bus_out, w); end
    endtask

    task automatic test_ena_freeze();
        int t, tf, bad;
        logic [7:0] div, w, sw;
        logic fclk, fout;
        div = 8'($urandom_range(0, 3)); w = 8'($urandom); sw = 8'($urandom);
        s_cpol = 1'($urandom); s_cpha = 1'($urandom); loop_en = 1'b0; s_tx_word = sw;
        cpol_in = s_cpol; cpha_in = s_cpha; clk_div = div; bus_in = w;
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 1;
        tf = W * (int'(div) + 1) + 1;
        while (t < tf) begin tick(); t++; end
        ena = 1'b0;
        fclk = spi_clk; fout = spi_out;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick(); t++;
            if (spi_clk !== fclk || spi_out !== fout || spi_ss !== 1'b0) bad++;
        end
        ena = 1'b1;
        while (done !== 1'b1 && t < 200) begin tick(); t++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL ena_frozen_pins: %0d bad cycles want 0", bad); end
        checks++; if (t != exp_done(int'(div)) + 5) begin errors++; $display("FAIL ena_done_delay: got %0d want %0d", t, exp_done(int'(div)) + 5); end
        checks++; if (bus_out !== sw) begin errors++; $display("FAIL ena_bus_out: got %h want %h", bus_out, sw); end
        checks++; if (slv_rcv !== w) begin errors++; $display("FAIL ena_slave_rx: got %h want %h", slv_rcv, w); end
        tick(); tick();
        ena = 1'b0; start = 1'b1;
        tick(); tick(); tick();
        checks++; if (spi_ss !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ena_start_ignored: ss %b busy %b want 1 0", spi_ss, busy); end
        start = 1'b0; ena = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int dt, e0, g0;
        logic [7:0] div, w, sw;
        logic pol, pha, cb;
        for (int n = 0; n < 10; n++) begin
            div = 8'($urandom_range(0, 4)); w = 8'($urandom); sw = 8'($urandom);
            pol = 1'($urandom); pha = 1'($urandom);
            e0 = mon_edges; g0 = mon_glitch;
            do_xfer(w, sw, pol, pha, div, 1'b0, 1'b1, dt, cb);
            checks++; if (dt != exp_done(int'(div))) begin errors++; $display("FAIL rand%0d_done: got %0d want %0d", n, dt, exp_done(int'(div))); end
            checks++; if (bus_out !== sw) begin errors++; $display("FAIL rand%0d_bus_out: got %h want %h", n, bus_out, sw); end
            checks++; if (slv_rcv !== w) begin errors++; $display("FAIL rand%0d_slave_rx: got %h want %h", n, slv_rcv, w); end
            checks++; if (mon_edges - e0 != 2 * W || mon_glitch != g0) begin errors++; $display("FAIL rand%0d_bus: edges %0d glitches %0d want %0d 0", n, mon_edges - e0, mon_glitch - g0, 2 * W); end
        end
    endtask

    task automatic test_div_max();
        int dt;
        logic cb;
        logic [7:0] w;
        w = 8'($urandom);
        do_xfer(w, 8'h00, 1'b0, 1'b0, 8'd255, 1'b1, 1'b0, dt, cb);
        checks++; if (dt != exp_done(255)) begin errors++; $display("FAIL divmax_done: got %0d want %0d", dt, exp_done(255)); end
        checks++; if (bus_out !== w) begin errors++; $display("FAIL divmax_bus_out: got %h want %h", bus_out, w); end
    endtask

    initial begin
        test_reset();
        test_mode0_loopback();
        test_mode3_slave();
        test_modes_1_2();
        test_back_to_back();
        test_reset_mid();
        test_ena_freeze();
        test_random();
        test_div_max();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
